// File: rtl/carregador_entrada.sv
// Serial-to-parallel loader: assembles 4-bit words MSB first, offers each
// word with a one-cycle ready pulse and waits for the consumer's fim.
module carregador_entrada (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       fim,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       ready,
    output logic       ocupado,
    output logic       erro,
    output logic [7:0] palavras
);

    localparam int unsigned WORD_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned TMO_W  = 4;
    localparam int unsigned PAL_W  = 8;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(15);

    typedef enum logic [1:0] {
        LIVRE,
        CARGA,
        OFERTA,
        ESPERA
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ready_q, ready_d;
    logic                erro_q, erro_d;
    logic [PAL_W-1:0]    palavras_q, palavras_d;
    logic [WORD_W-1:0]   shifted;

    assign shifted = {shreg_q[WORD_W-2:0], bit_in};

    // Next-state and datapath decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        ready_d    = 1'b0;
        erro_d     = erro_q;
        palavras_d = palavras_q;

        case (state_q)
            LIVRE: begin
                if (bit_valid) begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = CARGA;
                end
            end
            CARGA: begin
                if (bit_valid) begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_BIT) begin
                        word_d  = shifted;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                        state_d = OFERTA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OFERTA: begin
                palavras_d = palavras_q + PAL_W'(1);
                tmo_d      = '0;
                state_d    = ESPERA;
                if (bit_valid) begin
                    erro_d = 1'b1;
                end
            end
            ESPERA: begin
                if (fim) begin
                    // A bit arriving with fim opens the next word immediately
                    if (bit_valid) begin
                        shreg_d = shifted;
                        cnt_d   = CNT_W'(1);
                        state_d = CARGA;
                    end else begin
                        state_d = LIVRE;
                    end
                end else begin
                    if (bit_valid) begin
                        erro_d = 1'b1;
                    end
                    if (tmo_q == TMO_MAX) begin
                        erro_d  = 1'b1;
                        tmo_d   = '0;
                        state_d = LIVRE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: begin
                state_d = LIVRE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= LIVRE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            erro_q     <= 1'b0;
            palavras_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            erro_q     <= erro_d;
            palavras_q <= palavras_d;
        end
    end

    assign a        = word_q[3];
    assign b        = word_q[2];
    assign c        = word_q[1];
    assign d        = word_q[0];
    assign ready    = ready_q;
    assign erro     = erro_q;
    assign palavras = palavras_q;
    assign ocupado  = (state_q == OFERTA) || (state_q == ESPERA);

endmodule

// File: doc/carregador_entrada.md
CARREGADOR_ENTRADA -- requirements
Module: carregador_entrada

Interface
REQ-001 The block SHALL have the port `clock`: input, 1 bit; single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit; active-low; asynchronous assert; release takes effect at the next rising `clock`.
REQ-003 The block SHALL have the port `bit_in`: input, 1 bit; serial data bit, MSB of the word first.
REQ-004 The block SHALL have the port `bit_valid`: input, 1 bit; `bit_in` is valid in this cycle.
REQ-005 The block SHALL have the port `fim`: input, 1 bit; the downstream consumer has finished the current word.
REQ-006 The block SHALL have the ports `a`, `b`, `c` and `d`: each an output, 1 bit, registered; the assembled word, with `a`=first bit and `d`=fourth bit.
REQ-007 The block SHALL have the port `ready`: output, 1 bit, registered; a one-cycle pulse meaning a new word is present on `a`..`d`.
REQ-008 The block SHALL have the port `ocupado`: output, 1 bit; high while a word is awaiting `fim` (states OFERTA and ESPERA).
REQ-009 The block SHALL have the port `erro`: output, 1 bit; sticky flag set by a dropped bit or a timeout.
REQ-010 The block SHALL have the port `palavras`: output, 8 bits; count of words delivered; wraps from 255 to 0.

Function
REQ-011 The FSM SHALL have four states (LIVRE, CARGA, OFERTA, ESPERA) plus a 2-bit bit counter `cnt`, a 4-bit shift register and a 4-bit timeout counter `tmo`.
REQ-012 In LIVRE, `bit_valid`=1 SHALL shift `bit_in` into the shift register, set `cnt`=1 and move the FSM to CARGA; `fim` SHALL be ignored in LIVRE.
REQ-013 In CARGA, each `bit_valid`=1 SHALL shift in one bit and increment `cnt`; cycles with `bit_valid`=0 SHALL hold state, with no timeout.
REQ-014 On the 4th accepted bit, the full word SHALL be written to `a`..`d` in the same edge and the FSM SHALL go to OFERTA; `cnt` SHALL return to 0.
REQ-015 OFERTA SHALL last exactly one cycle: `ready`=1, `palavras` increments on that edge, `tmo` clears to 0, and the FSM SHALL go to ESPERA.
REQ-016 Latency SHALL be one cycle: `ready` is high the cycle after the edge that accepted the 4th bit.
REQ-017 In ESPERA, `fim`=1 SHALL move the FSM to LIVRE; otherwise `tmo` increments each cycle.
REQ-018 When `tmo` reaches 15 in ESPERA without `fim`, the block SHALL set `erro`=1 and go to LIVRE.
REQ-019 A `fim` in ESPERA together with `bit_valid` in the same cycle SHALL accept the bit as bit 1 of the next word (`cnt`=1) and go directly to CARGA.
REQ-020 A `bit_valid` in OFERTA, or in ESPERA without `fim`, SHALL drop the bit and set `erro`=1.
REQ-021 A `fim` in OFERTA SHALL be ignored; the FSM still proceeds to ESPERA.
REQ-022 `a`..`d` SHALL hold their value from the load edge until the next 4th-bit load; partial shifting SHALL NOT disturb `a`..`d`.
REQ-023 `erro` SHALL clear only by reset.
REQ-024 `ocupado` SHALL be the combinational decode of (state==OFERTA or state==ESPERA).

Reset
REQ-025 On `reset`=0, the block SHALL asynchronously set state=LIVRE, `cnt`=0, `tmo`=0, shift register=0, `a`=`b`=`c`=`d`=0, `ready`=0, `erro`=0 and `palavras`=0.
REQ-026 A reset asserted mid-word (CARGA) SHALL discard the partial bits, and the next word SHALL start from bit 1.
REQ-027 A reset asserted in ESPERA SHALL return the block to LIVRE; any `fim` arriving after reset SHALL be ignored.
REQ-028 `ready` SHALL NOT pulse during reset or in the first cycle after reset release.

Verification
REQ-029 Scenario "load": reset, then serial bits 1,0,1,1 with `bit_valid`=1 on consecutive cycles -> `abcd`=1011 and `ready`=1 for one cycle, starting at the cycle after the 4th bit; `palavras`=1; `ocupado`=1.
REQ-030 Scenario "handshake": after the load scenario, `fim`=1 two cycles after `ready` -> `ocupado`=0 the next cycle; send 0,1,1,0 -> `abcd`=0110 and `palavras`=2.
REQ-031 Scenario "drop": send word 1111, then `bit_valid`=1 in ESPERA without `fim` -> `erro`=1, `abcd` still 1111, and the dropped bit does not count toward the next word.
REQ-032 Scenario "timeout": load a word and never assert `fim` -> `erro`=1 and `ocupado`=0 after 16 cycles in ESPERA; the next word loads normally.
REQ-033 Scenario "simultaneous": in ESPERA, `fim`=1 and `bit_valid`=1 with `bit_in`=1, then bits 0,0,1 -> `abcd`=1001 and `erro`=0.
REQ-034 Scenario "reset mid-word": send bits 1,1, pulse `reset` low, then send 0,0,0,1 -> `abcd`=0001 and `palavras`=1.
REQ-035 Scenario "wrap": deliver 256 words with `fim` handshakes -> `palavras` wraps from 255 to 0.
